// File: rtl/matmul_ctrl.sv
// rtl/matmul_ctrl.sv - C = A x B sequencer driving A/B read and C write RAM ports
// Optional busy_cycles port and counter when MATMUL_CTRL_CYCLE_CNT_EN is defined.
module matmul_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int SIZE_WIDTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH+SIZE_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [SIZE_WIDTH-1:0] dim_n,
  input  logic [SIZE_WIDTH-1:0] dim_m,
  input  logic [SIZE_WIDTH-1:0] dim_p,
  output logic                  ready,
  output logic                  done,
  output logic                  a_en,
  output logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_data,
  output logic                  b_en,
  output logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_data,
  output logic                  c_we,
  output logic [ADDR_WIDTH-1:0] c_addr,
  output logic [ACC_WIDTH-1:0]  c_data
`ifdef MATMUL_CTRL_CYCLE_CNT_EN
  ,
  output logic [31:0]           busy_cycles
`endif
);

  typedef enum logic [2:0] {IDLE, CALC, DRAIN, WRITE, DONE} state_t;

  localparam logic [SIZE_WIDTH-1:0] S_ZERO = '0;
  localparam logic [SIZE_WIDTH-1:0] S_ONE  = SIZE_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] A_ONE  = ADDR_WIDTH'(1);

  state_t                  state_q;
  logic [SIZE_WIDTH-1:0]   n_q, m_q, p_q, i_q, j_q, k_q;
  logic                    ready_q, done_q, a_en_q, b_en_q, c_we_q;
  logic                    vld_q, first_q;
  logic [ADDR_WIDTH-1:0]   a_addr_q, b_addr_q, c_addr_q, a_base_q;
  logic [ACC_WIDTH-1:0]    acc_q, acc_d, prod_d;
  logic signed [2*DATA_WIDTH-1:0] a_ext, b_ext, prod;

  assign a_ext  = {{DATA_WIDTH{a_data[DATA_WIDTH-1]}}, a_data};
  assign b_ext  = {{DATA_WIDTH{b_data[DATA_WIDTH-1]}}, b_data};
  assign prod   = a_ext * b_ext;
  assign prod_d = {{(ACC_WIDTH-2*DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod};
  assign acc_d  = first_q ? prod_d : acc_q + prod_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      n_q      <= '0;
      m_q      <= '0;
      p_q      <= '0;
      i_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      a_en_q   <= 1'b0;
      b_en_q   <= 1'b0;
      c_we_q   <= 1'b0;
      vld_q    <= 1'b0;
      first_q  <= 1'b0;
      a_addr_q <= '0;
      b_addr_q <= '0;
      c_addr_q <= '0;
      a_base_q <= '0;
      acc_q    <= '0;
    end else begin
      // vld_q/first_q describe the read issued last cycle, whose data is on a_data/b_data now
      vld_q <= 1'b0;
      if (vld_q) acc_q <= acc_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            n_q      <= dim_n;
            m_q      <= dim_m;
            p_q      <= dim_p;
            i_q      <= '0;
            j_q      <= '0;
            k_q      <= '0;
            a_addr_q <= '0;
            b_addr_q <= '0;
            c_addr_q <= '0;
            a_base_q <= '0;
            ready_q  <= 1'b0;
            if (dim_n == S_ZERO || dim_m == S_ZERO || dim_p == S_ZERO) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= CALC;
              a_en_q  <= 1'b1;
              b_en_q  <= 1'b1;
            end
          end
        end
        CALC: begin
          vld_q    <= 1'b1;
          first_q  <= (k_q == S_ZERO);
          a_addr_q <= a_addr_q + A_ONE;
          b_addr_q <= b_addr_q + ADDR_WIDTH'(p_q);
          if (k_q == m_q - S_ONE) begin
            state_q <= DRAIN;
            a_en_q  <= 1'b0;
            b_en_q  <= 1'b0;
          end else begin
            k_q <= k_q + S_ONE;
          end
        end
        DRAIN: begin
          state_q <= WRITE;
          c_we_q  <= 1'b1;
        end
        WRITE: begin
          c_we_q   <= 1'b0;
          c_addr_q <= c_addr_q + A_ONE;
          k_q      <= '0;
          if (j_q != p_q - S_ONE) begin
            j_q      <= j_q + S_ONE;
            a_addr_q <= a_base_q;
            b_addr_q <= ADDR_WIDTH'(j_q) + A_ONE;
            state_q  <= CALC;
            a_en_q   <= 1'b1;
            b_en_q   <= 1'b1;
          end else if (i_q != n_q - S_ONE) begin
            j_q      <= '0;
            i_q      <= i_q + S_ONE;
            a_base_q <= a_base_q + ADDR_WIDTH'(m_q);
            a_addr_q <= a_base_q + ADDR_WIDTH'(m_q);
            b_addr_q <= '0;
            state_q  <= CALC;
            a_en_q   <= 1'b1;
            b_en_q   <= 1'b1;
          end else begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign ready  = ready_q;
  assign done   = done_q;
  assign a_en   = a_en_q;
  assign b_en   = b_en_q;
  assign c_we   = c_we_q;
  assign a_addr = a_addr_q;
  assign b_addr = b_addr_q;
  assign c_addr = c_addr_q;
  assign c_data = acc_q;

`ifdef MATMUL_CTRL_CYCLE_CNT_EN
  logic [31:0] busy_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      busy_q <= '0;
    end else if (state_q == IDLE) begin
      if (start) busy_q <= '0;
    end else if (busy_q != 32'hFFFF_FFFF) begin
      busy_q <= busy_q + 32'd1;
    end
  end

  assign busy_cycles = busy_q;
`endif

endmodule

// File: tb/tb_matmul_ctrl.sv
// tb/tb_matmul_ctrl.sv - randomized self-checking bench for matmul_ctrl against a cycle-schedule model
module tb_matmul_ctrl;
  localparam int DW = 16;
  localparam int SW = 8;
  localparam int AW = 16;
  localparam int CW = 2*DW+SW;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [SW-1:0] dim_n = '0, dim_m = '0, dim_p = '0;
  logic          ready, done, a_en, b_en, c_we;
  logic [AW-1:0] a_addr, b_addr, c_addr;
  logic [DW-1:0] a_data = '0, b_data = '0;
  logic [CW-1:0] c_data;
`ifdef MATMUL_CTRL_CYCLE_CNT_EN
  logic [31:0]   busy_cycles;
`endif

  matmul_ctrl #(.DATA_WIDTH(DW), .SIZE_WIDTH(SW), .ADDR_WIDTH(AW), .ACC_WIDTH(CW)) dut (
    .clock(clock), .reset(reset), .start(start),
    .dim_n(dim_n), .dim_m(dim_m), .dim_p(dim_p),
    .ready(ready), .done(done),
    .a_en(a_en), .a_addr(a_addr), .a_data(a_data),
    .b_en(b_en), .b_addr(b_addr), .b_data(b_data),
    .c_we(c_we), .c_addr(c_addr), .c_data(c_data)
`ifdef MATMUL_CTRL_CYCLE_CNT_EN
    , .busy_cycles(busy_cycles)
`endif
  );

  always #5 clock = ~clock;

  int     ma [0:4095];
  int     mb [0:4095];
  longint ec [0:255];
  int     rn, rm, rp;
  int     t = 0;
  int     done_t = -1;
  bit     active = 1'b0;
  bit     idle_chk = 1'b0;
  int     checks = 0;
  int     errors = 0;
  logic [AW-1:0] cap_addr[$];
  logic [CW-1:0] cap_data[$];

  // single-port RAMs with one cycle of read latency
  always @(posedge clock) begin
    if (a_en) a_data <= DW'(ma[a_addr[11:0]]);
    if (b_en) b_data <= DW'(mb[b_addr[11:0]]);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0d actual=%0h required=%0h", nm, t, act, exp);
    end
  endtask

  // Expected behaviour at cycle t after the accept edge: element e = t/(M+2) reads for
  // phases 0..M-1, idles one phase, writes on phase M+1; done follows the last element.
  always @(negedge clock) begin : cmp
    int total, e, ph, ei, ej;
    bit calc, wr;
    logic [CW-1:0] ecd;
    if (active) begin
      total = (rn == 0 || rm == 0 || rp == 0) ? 0 : rn*rp*(rm+2);
      e = 0; ph = 0; ei = 0; ej = 0;
      if (t < total) begin
        e  = t / (rm+2);
        ph = t % (rm+2);
        ei = e / rp;
        ej = e % rp;
      end
      calc = (t < total) && (ph < rm);
      wr   = (t < total) && (ph == rm+1);
      chk("ready", 64'(ready), 64'(t > total));
      chk("done", 64'(done), 64'(t == total));
      chk("a_en", 64'(a_en), 64'(calc));
      chk("b_en", 64'(b_en), 64'(calc));
      chk("c_we", 64'(c_we), 64'(wr));
      if (calc) begin
        chk("a_addr", 64'(a_addr), 64'(AW'(ei*rm+ph)));
        chk("b_addr", 64'(b_addr), 64'(AW'(ph*rp+ej)));
      end
      if (wr) begin
        ecd = CW'(ec[e]);
        chk("c_addr", 64'(c_addr), 64'(AW'(e)));
        chk("c_data", 64'(c_data), 64'(ecd));
      end
`ifdef MATMUL_CTRL_CYCLE_CNT_EN
      chk("busy_cycles", 64'(busy_cycles), 64'((t <= total) ? t : total+1));
`endif
      if (c_we) begin
        cap_addr.push_back(c_addr);
        cap_data.push_back(c_data);
      end
      if (done && done_t < 0) done_t = t;
      t++;
      if (t > total+1) active = 1'b0;
    end else if (idle_chk) begin
      chk("idle_ready", 64'(ready), 64'd1);
      chk("idle_done", 64'(done), 64'd0);
      chk("idle_a_en", 64'(a_en), 64'd0);
      chk("idle_b_en", 64'(b_en), 64'd0);
      chk("idle_c_we", 64'(c_we), 64'd0);
    end
  end

  task automatic fill_rand(input int n, input int m, input int p);
    for (int x = 0; x < n*m; x++) ma[x] = int'($urandom_range(0, 65535)) - 32768;
    for (int x = 0; x < m*p; x++) mb[x] = int'($urandom_range(0, 65535)) - 32768;
  endtask

  task automatic run(input int n, input int m, input int p, input int busy_t, input int abort_t);
    int cyc;
    cap_addr.delete();
    cap_data.delete();
    done_t = -1;
    rn = n; rm = m; rp = p;
    for (int i = 0; i < n; i++)
      for (int j = 0; j < p; j++) begin
        longint s = 0;
        for (int k = 0; k < m; k++) s += longint'(ma[i*m+k]) * longint'(mb[k*p+j]);
        ec[i*p+j] = s;
      end
    @(negedge clock); #1;
    dim_n = SW'(n); dim_m = SW'(m); dim_p = SW'(p);
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    idle_chk = 1'b0;
    t = 0;
    active = 1'b1;
    dim_n = SW'($urandom); dim_m = SW'($urandom); dim_p = SW'($urandom);
    cyc = 0;
    while (active && cyc < 5000) begin
      @(negedge clock); #1;
      cyc++;
      if (t == busy_t) begin
        start = 1'b1; dim_n = 8'd1; dim_m = 8'd1; dim_p = 8'd1;
      end else begin
        start = 1'b0;
      end
      if (abort_t >= 0 && t == abort_t+1) begin
        reset = 1'b1;
        active = 1'b0;
      end
    end
    start = 1'b0;
    chk("run_finished", 64'(active), 64'd0);
    active = 1'b0;
    if (abort_t >= 0) begin
      @(negedge clock); #1;
      chk("rst_ready", 64'(ready), 64'd1);
      chk("rst_c_we", 64'(c_we), 64'd0);
      chk("rst_a_en", 64'(a_en), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      reset = 1'b0;
    end
    idle_chk = 1'b1;
  endtask

  initial begin
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset_ready", 64'(ready), 64'd1);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_a_en", 64'(a_en), 64'd0);
    chk("reset_b_en", 64'(b_en), 64'd0);
    chk("reset_c_we", 64'(c_we), 64'd0);
    chk("reset_addrs", 64'({a_addr, b_addr, c_addr}), 64'd0);
    chk("reset_c_data", 64'(c_data), 64'd0);
`ifdef MATMUL_CTRL_CYCLE_CNT_EN
    chk("reset_busy", 64'(busy_cycles), 64'd0);
`endif
    #1 reset = 1'b0;
    idle_chk = 1'b1;

    // 2x2x2 with hand-computed result
    ma[0] = 1; ma[1] = 2; ma[2] = 3; ma[3] = 4;
    mb[0] = 5; mb[1] = 6; mb[2] = 7; mb[3] = 8;
    run(2, 2, 2, -1, -1);
    chk("lit22_nwr", 64'(cap_data.size()), 64'd4);
    if (cap_data.size() == 4) begin
      chk("lit22_c0", 64'(cap_data[0]), 64'd19);
      chk("lit22_c1", 64'(cap_data[1]), 64'd22);
      chk("lit22_c2", 64'(cap_data[2]), 64'd43);
      chk("lit22_c3", 64'(cap_data[3]), 64'd50);
      chk("lit22_a3", 64'(cap_addr[3]), 64'd3);
    end
    chk("lit22_lat", 64'(done_t), 64'd16);
    repeat (3) @(negedge clock);
`ifdef MATMUL_CTRL_CYCLE_CNT_EN
    #1 chk("lit22_busy_hold", 64'(busy_cycles), 64'd17);
`endif

    // signed 1x3x1
    ma[0] = -1; ma[1] = 2; ma[2] = -3;
    mb[0] = 4;  mb[1] = -5; mb[2] = 6;
    run(1, 3, 1, -1, -1);
    chk("lit_sgn_nwr", 64'(cap_data.size()), 64'd1);
    if (cap_data.size() == 1) chk("lit_sgn_c", 64'(cap_data[0]), 64'h00FF_FFFF_FFE0);
    chk("lit_sgn_lat", 64'(done_t), 64'd5);

    // zero dimension: done on the cycle right after accept, no RAM traffic
    run(2, 0, 3, -1, -1);
    chk("zero_lat", 64'(done_t), 64'd0);
    chk("zero_nwr", 64'(cap_data.size()), 64'd0);

    // second start while busy must be ignored
    fill_rand(2, 3, 2);
    run(2, 3, 2, 2, -1);
    chk("busy_nwr", 64'(cap_data.size()), 64'd4);

    // reset during the write of element 4 of a 3x3x3 run, then a clean rerun
    fill_rand(3, 3, 3);
    run(3, 3, 3, -1, 4*5+4);
    chk("abort_nwr", 64'(cap_data.size()), 64'd5);
    chk("abort_no_done", 64'(done_t), 64'hFFFF_FFFF_FFFF_FFFF);
    repeat (20) @(negedge clock);
    run(3, 3, 3, -1, -1);
    chk("rerun_nwr", 64'(cap_data.size()), 64'd9);

    // extreme operands stress sign extension and wide accumulation
    for (int x = 0; x < 16; x++) begin ma[x] = -32768; mb[x] = (x % 2) ? -32768 : 32767; end
    run(2, 8, 2, -1, -1);

    for (int r = 0; r < 8; r++) begin
      int n, m, p;
      n = int'($urandom_range(1, 4));
      m = int'($urandom_range(1, 6));
      p = int'($urandom_range(1, 4));
      if (r == 5) p = 0;
      fill_rand(n, m, p);
      run(n, m, p, -1, -1);
    end

    repeat (4) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
